tabla_meta_buffer: RTL and testbench

Per-PE writable metadata/constant buffer, the parametrised successor to the fixed per-PE constant ROM. Holds `2**addrLen` words of `dataLen` bits. After reset it self-initialises to a per-PE default image: address 0 holds 1 for PEs selected by a mask, and every other word is 0. It then accepts run-time loads from the PE-bus loader and serves registered reads to the PE datapath.

---
 rtl/tabla_buf_pkg.sv | 18 +
 rtl/tabla_sdp_ram.sv | 22 ++
 rtl/tabla_meta_buffer.sv | 95 +++++++++
 tb/tb_tabla_meta_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tabla_buf_pkg.sv
// Shared types and helpers for the per-PE metadata buffer.
package tabla_buf_pkg;

    typedef enum logic {INIT, RUN} buf_state_t;

    localparam int TABLA_NUM_PE = 64;

    // Default image word: only address 0 can be non-zero, carrying this PE's mask bit.
    function automatic logic [63:0] init_word(input logic [31:0] addr, input logic [63:0] mask,
                                              input int pe_id, input int data_len);
        logic [63:0] w;
        w    = '0;
        w[0] = (addr == 32'd0) ? mask[6'(pe_id)] : 1'b0;
        if (data_len < 64) w = w & ((64'd1 << data_len) - 64'd1);
        return w;
    endfunction

endpackage

// File: rtl/tabla_sdp_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module tabla_sdp_ram #(
    parameter int addrLen = 6,
    parameter int dataLen = 16
) (
    input  logic               clk,
    input  logic               we,
    input  logic [addrLen-1:0] waddr,
    input  logic [dataLen-1:0] wdata,
    input  logic [addrLen-1:0] raddr,
    output logic [dataLen-1:0] rdata
);

    logic [dataLen-1:0] mem [2**addrLen];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tabla_meta_buffer.sv
// Per-PE writable metadata buffer: self-initialises to a default image, then serves loads and reads.
module tabla_meta_buffer
    import tabla_buf_pkg::*;
#(
    parameter int          addrLen  = 6,
    parameter int          dataLen  = 16,
    parameter int          peId     = 0,
    parameter logic [63:0] initMask = 64'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    output logic               busy,
    input  logic               wr_en,
    input  logic [addrLen-1:0] wr_addr,
    input  logic [dataLen-1:0] wr_data,
    output logic               wr_ready,
    input  logic               rd_en,
    input  logic [addrLen-1:0] rd_addr,
    output logic [dataLen-1:0] data_out,
    output logic               rd_valid
);

    buf_state_t         state, state_next;
    logic [addrLen-1:0] ptr, ptr_next;
    logic [dataLen-1:0] init_data, rd_word, ram_rdata;
    logic               ram_we, rd_accept;
    logic [addrLen-1:0] ram_waddr;
    logic [dataLen-1:0] ram_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            INIT: begin
                ptr_next = ptr + 1'b1;
                if (ptr == '1) state_next = RUN;
                if (clear) begin
                    state_next = INIT;
                    ptr_next   = '0;
                end
            end
            RUN: begin
                if (clear) begin
                    state_next = INIT;
                    ptr_next   = '0;
                end
            end
            default: state_next = INIT;
        endcase
    end

    // busy decodes a single state flop, so it has no path from the inputs.
    assign busy     = (state == INIT);
    assign wr_ready = ~busy;

    assign init_data = dataLen'(init_word(32'(ptr), initMask, peId, dataLen));
    assign ram_we    = busy | wr_en;
    assign ram_waddr = busy ? ptr : wr_addr;
    assign ram_wdata = busy ? init_data : wr_data;

    tabla_sdp_ram #(.addrLen(addrLen), .dataLen(dataLen)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Write-first bypass for a same-cycle read/write collision.
    assign rd_accept = rd_en & ~busy;
    assign rd_word   = (wr_en && (wr_addr == rd_addr)) ? wr_data : ram_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) data_out <= rd_word;
        end
    end

endmodule

// File: tb/tb_tabla_meta_buffer.sv
// Randomized + directed bench for tabla_meta_buffer against a behavioural model (two PE configs).
module tb_tabla_meta_buffer;

    localparam int          AW     = 6;
    localparam int          DW     = 16;
    localparam int          DEPTH  = 64;
    localparam int          PE_A   = 3;
    localparam logic [63:0] MASK_A = 64'h0000_0000_0000_000C;
    localparam int          PE_B   = 0;
    localparam logic [63:0] MASK_B = 64'hFFFF_FFFF_FFFF_FFFE;

    logic          clk = 1'b0;
    logic          reset, clear, wr_en, rd_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;

    logic          busy_a, wr_ready_a, rd_valid_a;
    logic [DW-1:0] data_out_a;
    logic          busy_b, wr_ready_b, rd_valid_b;
    logic [DW-1:0] data_out_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DW-1:0] m_a [DEPTH];
    logic [DW-1:0] m_b [DEPTH];
    logic [DW-1:0] exp_a, exp_b;
    logic          exp_valid;
    int            init_left;

    always #5 clk = ~clk;

    tabla_meta_buffer #(.addrLen(AW), .dataLen(DW), .peId(PE_A), .initMask(MASK_A)) u_dut_a (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready_a),
        .rd_en(rd_en), .rd_addr(rd_addr), .data_out(data_out_a), .rd_valid(rd_valid_a)
    );

    tabla_meta_buffer #(.addrLen(AW), .dataLen(DW), .peId(PE_B), .initMask(MASK_B)) u_dut_b (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready_b),
        .rd_en(rd_en), .rd_addr(rd_addr), .data_out(data_out_b), .rd_valid(rd_valid_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic load_defaults();
        for (int i = 0; i < DEPTH; i++) begin
            m_a[i] = (i == 0 && MASK_A[PE_A]) ? 16'd1 : 16'd0;
            m_b[i] = (i == 0 && MASK_B[PE_B]) ? 16'd1 : 16'd0;
        end
    endtask

    task automatic model_reset();
        init_left = DEPTH;
        exp_a     = '0;
        exp_b     = '0;
        exp_valid = 1'b0;
        load_defaults();
    endtask

    task automatic model_edge();
        if (reset) return;
        if (init_left > 0) begin
            exp_valid = 1'b0;
            if (clear) init_left = DEPTH;
            else       init_left--;
        end else begin
            exp_valid = rd_en;
            if (rd_en) begin
                if (wr_en && wr_addr == rd_addr) begin
                    exp_a = wr_data;
                    exp_b = wr_data;
                end else begin
                    exp_a = m_a[rd_addr];
                    exp_b = m_b[rd_addr];
                end
            end
            if (wr_en) begin
                m_a[wr_addr] = wr_data;
                m_b[wr_addr] = wr_data;
            end
            if (clear) begin
                init_left = DEPTH;
                load_defaults();
            end
        end
    endtask

    task automatic check_outputs();
        chk("busy_a",     32'(busy_a),     32'(init_left > 0));
        chk("wr_ready_a", 32'(wr_ready_a), 32'(init_left == 0));
        chk("rd_valid_a", 32'(rd_valid_a), 32'(exp_valid));
        chk("data_out_a", 32'(data_out_a), 32'(exp_a));
        chk("busy_b",     32'(busy_b),     32'(init_left > 0));
        chk("rd_valid_b", 32'(rd_valid_b), 32'(exp_valid));
        chk("data_out_b", 32'(data_out_b), 32'(exp_b));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] ra, input logic clr);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra; clear = clr;
        tick();
        wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_init(input string tag);
        int budget;
        budget = 0;
        while (busy_a && budget < 200) begin
            idle(1);
            budget++;
        end
        chk(tag, 32'(busy_a), 32'd0);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        model_reset();
        #1;
        check_outputs();
        tick();
        tick();
        reset = 1'b0;

        // Init length: busy through edge 63, low from cycle 64
        idle(63);
        chk("busy_at_63", 32'(busy_a), 32'd1);
        idle(1);
        chk("busy_at_64", 32'(busy_a), 32'd0);

        drive(1'b0, '0, '0, 1'b1, 6'd0, 1'b0);
        chk("init_addr0_a", 32'(data_out_a), 32'h0001);
        chk("init_addr0_b", 32'(data_out_b), 32'h0000);
        chk("init_valid", 32'(rd_valid_a), 32'd1);
        drive(1'b0, '0, '0, 1'b1, 6'd5, 1'b0);
        chk("init_addr5", 32'(data_out_a), 32'h0000);
        idle(1);
        chk("valid_drops", 32'(rd_valid_a), 32'd0);

        // Write then read, then same-cycle bypass
        drive(1'b1, 6'd10, 16'hBEEF, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 6'd10, 1'b0);
        chk("wr_then_rd", 32'(data_out_a), 32'hBEEF);
        drive(1'b1, 6'd10, 16'h1234, 1'b1, 6'd10, 1'b0);
        chk("bypass", 32'(data_out_a), 32'h1234);
        drive(1'b0, '0, '0, 1'b1, 6'd10, 1'b0);
        chk("bypass_stored", 32'(data_out_a), 32'h1234);

        // Clear in RUN after overwriting address 0; same-cycle read still serviced
        drive(1'b1, 6'd0, 16'hAAAA, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 6'd0, 1'b1);
        chk("clear_rd_serviced", 32'(data_out_a), 32'hAAAA);
        chk("clear_busy_rises", 32'(busy_a), 32'd1);

        // Busy blocking at cycle 20 of init
        idle(19);
        chk("blk_wr_ready", 32'(wr_ready_a), 32'd0);
        drive(1'b1, 6'd7, 16'h5555, 1'b1, 6'd7, 1'b0);
        chk("blk_rd_valid", 32'(rd_valid_a), 32'd0);
        chk("blk_data_held", 32'(data_out_a), 32'hAAAA);
        wait_init("init_after_clear");
        drive(1'b0, '0, '0, 1'b1, 6'd7, 1'b0);
        chk("blk_wr_dropped", 32'(data_out_a), 32'h0000);
        drive(1'b0, '0, '0, 1'b1, 6'd0, 1'b0);
        chk("clear_addr0", 32'(data_out_a), 32'h0001);

        // Reset at cycle 30 of an init, with data_out non-zero beforehand
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        idle(29);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_data_out", 32'(data_out_a), 32'h0000);
        chk("rst_busy", 32'(busy_a), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid_a), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        idle(63);
        chk("rst_busy_63", 32'(busy_a), 32'd1);
        idle(1);
        chk("rst_busy_64", 32'(busy_a), 32'd0);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, '0, 1'b1, AW'(i), 1'b0);

        // Randomized traffic with collisions and occasional clear
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] wa, ra;
            wa = AW'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            drive(1'($urandom_range(0, 1)), wa, DW'($urandom),
                  1'($urandom_range(0, 1)), ra, ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
